bcd_long_divider: RTL and testbench
===================================

BCD_LONG_DIVIDER -- requirements
Module: bcd_long_divider

Interface
REQ-001 SHALL have parameter DIGITS, default 4 (legal range 2..8), giving the number of BCD digits per operand.
REQ-002 SHALL have a single clock; reset is asynchronous and active-high.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-006 SHALL have port dividend, input, 4*DIGITS bits: packed BCD, most significant digit in the top nibble.
REQ-007 SHALL have port divisor, input, 4*DIGITS bits: packed BCD.
REQ-008 SHALL have port quotient, output, 4*DIGITS bits: registered BCD result.
REQ-009 SHALL have port remainder, output, 4*DIGITS bits: registered BCD result.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a result is valid.
REQ-012 SHALL have port div_by_zero, output, 1 bit: error flag; registered and updated at DONE entry.
REQ-013 SHALL have port bcd_err, output, 1 bit: error flag for an operand nibble greater than 9; registered and updated at DONE entry.

Function
REQ-014 SHALL implement the FSM states IDLE, SHIFT, SUB and DONE.
REQ-015 In IDLE with start=1, SHALL latch dividend and divisor into internal registers.
- Same edge: clear the internal remainder (DIGITS+1 digits) and the quotient shift register.
- Same edge: set the digit counter to DIGITS-1.
- Next state: SHIFT, unless REQ-020 or REQ-021 applies.
REQ-016 SHIFT SHALL perform a single transition.
- Internal remainder becomes remainder*10 + dividend digit[counter], i.e. a nibble shift-in.
- Current quotient digit is cleared.
- Next state: SUB.
REQ-017 SUB SHALL perform one of two actions per cycle.
- If internal remainder >= divisor (digit-wise compare, MSD first): subtract the divisor in BCD and increment the quotient digit (0..9); stay in SUB.
- Otherwise: shift the quotient digit into the quotient register. If counter=0, go to DONE; else decrement the counter and go to SHIFT.
REQ-018 Each dividend digit i SHALL cost exactly q_i+2 cycles, where q_i is the resulting quotient digit.
- DONE is entered Σ(q_i+2) edges after the start-sampling edge.
REQ-019 On DONE entry, the quotient and remainder outputs SHALL load the result.
- remainder output is the low DIGITS digits of the internal remainder; the result is always < divisor.
- done=1 for exactly one cycle; next state is IDLE.
REQ-020 If divisor equals 0 at start and all nibbles are valid, the block SHALL go directly to DONE on the next edge.
- Results: div_by_zero=1, quotient = all digits 9, remainder = dividend.
REQ-021 If any nibble of dividend or divisor exceeds 9 at start, the block SHALL go directly to DONE.
- Results: bcd_err=1, div_by_zero=0, quotient=0, remainder=0.
- bcd_err takes priority over div_by_zero.
REQ-022 A successful result SHALL clear both error flags.
REQ-023 start SHALL be ignored while busy=1, including during DONE; no queuing.
REQ-024 Outputs SHALL hold the previous result until the next DONE entry.
REQ-025 Changes on dividend or divisor after the start-sampling edge SHALL have no effect.
REQ-026 All BCD add/subtract arithmetic SHALL use per-digit decimal correction; internal binary values above 9 are never visible at the outputs.

Reset
REQ-027 rst=1 SHALL force, asynchronously, all of the following:
- FSM to IDLE.
- quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, bcd_err=0.
- All internal registers cleared.
REQ-028 Reset mid-operation SHALL abort the operation with no done pulse; the first start after release begins a fresh division.

Verification
REQ-029 dividend=1234, divisor=0012, start pulse -> done 11 edges after the start edge; quotient=0102; remainder=0010; both flags 0.
REQ-030 dividend=9999, divisor=0001 -> quotient=9999, remainder=0000; done exactly 44 edges after the start edge; busy high throughout.
REQ-031 divisor=0000, dividend=0456 -> done on the next edge; div_by_zero=1; quotient=9999; remainder=0456.
REQ-032 dividend=12A4, divisor=0003 -> done on the next edge; bcd_err=1; quotient=0000; remainder=0000.
REQ-033 A second start, with different operands, pulsed mid-division -> ignored; the first result (e.g. 0100/0007 -> 0014 r 0002) completes unchanged.
REQ-034 rst asserted 5 cycles into 9999/0001 -> all outputs 0 immediately; no done pulse; a subsequent 0050/0007 completes normally -> 0007 r 0001.

Source files
------------

// File: rtl/bcd_long_divider.sv
// -----------------------------------------------------------------------------
// bcd_long_divider
// Sequential restoring long divider on packed BCD operands. One dividend digit
// is brought down per SHIFT cycle, then SUB repeatedly subtracts the divisor in
// BCD (one subtraction per cycle) to build the quotient digit. Each digit costs
// q_i + 2 cycles. Division by zero and non-BCD operand nibbles short-circuit
// straight to DONE with an error flag.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start        division request, sampled only in IDLE
//   dividend     packed BCD, 4*DIGITS bits, MSD in top nibble
//   divisor      packed BCD, 4*DIGITS bits
//   quotient     registered BCD quotient (holds until next result)
//   remainder    registered BCD remainder (holds until next result)
//   busy         high in every state except IDLE
//   done         one-cycle pulse while the new result is presented
//   div_by_zero  registered error flag, updated when a result is loaded
//   bcd_err      registered error flag for an operand nibble above 9
// -----------------------------------------------------------------------------
module bcd_long_divider #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   dividend,
  input  logic [4*DIGITS-1:0]   divisor,
  output logic [4*DIGITS-1:0]   quotient,
  output logic [4*DIGITS-1:0]   remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic                  bcd_err
);

  localparam int W  = 4 * DIGITS;
  localparam int RW = W + 4;  // internal remainder carries one extra digit
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // True when every nibble of x is a legal BCD digit.
  function automatic logic bcd_valid(input logic [W-1:0] x);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (x[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // BCD subtract a - b with per-digit decimal borrow correction (a >= b).
  function automatic logic [RW-1:0] bcd_sub(input logic [RW-1:0] a,
                                            input logic [RW-1:0] b);
    logic            br;
    logic [4:0]      d;
    logic [RW-1:0]   r;
    br = 1'b0;
    r  = {RW{1'b0}};
    for (int i = 0; i < DIGITS + 1; i++) begin
      d = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0000, br};
      if (d[4]) begin
        r[4*i +: 4] = d[3:0] + 4'd10;
        br          = 1'b1;
      end else begin
        r[4*i +: 4] = d[3:0];
        br          = 1'b0;
      end
    end
    return r;
  endfunction

  state_t          state_r, state_s;
  logic [W-1:0]    dvd_r, dvs_r, quo_r;
  logic [RW-1:0]   rem_r;
  logic [3:0]      qdig_r;
  logic [CW-1:0]   cnt_r;

  logic [W-1:0]    quotient_r, remainder_r;
  logic            busy_r, done_r, div_by_zero_r, bcd_err_r;

  logic            ops_ok_s, dvs_zero_s, ge_s, last_s;
  logic [RW-1:0]   dvs_ext_s, diff_s;

  assign ops_ok_s   = bcd_valid(dividend) && bcd_valid(divisor);
  assign dvs_zero_s = (divisor == {W{1'b0}});
  assign dvs_ext_s  = {4'b0000, dvs_r};
  // Packed BCD orders like its binary image, so a plain compare equals the
  // MSD-first digit-wise compare.
  assign ge_s       = (rem_r >= dvs_ext_s);
  assign diff_s     = bcd_sub(rem_r, dvs_ext_s);
  assign last_s     = (cnt_r == {CW{1'b0}});

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (!ops_ok_s || dvs_zero_s) begin
            state_s = DONE;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: state_s = SUB;
      SUB: begin
        if (ge_s) begin
          state_s = SUB;
        end else if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Division datapath: operand latches, working remainder, quotient build-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_r  <= {W{1'b0}};
      dvs_r  <= {W{1'b0}};
      quo_r  <= {W{1'b0}};
      rem_r  <= {RW{1'b0}};
      qdig_r <= 4'd0;
      cnt_r  <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            dvd_r  <= dividend;
            dvs_r  <= divisor;
            quo_r  <= {W{1'b0}};
            rem_r  <= {RW{1'b0}};
            qdig_r <= 4'd0;
            cnt_r  <= CW'(DIGITS - 1);
          end
        end
        SHIFT: begin
          // remainder*10 + next dividend digit is a nibble shift-in in BCD
          rem_r  <= {rem_r[RW-5:0], dvd_r[{cnt_r, 2'b00} +: 4]};
          qdig_r <= 4'd0;
        end
        SUB: begin
          if (ge_s) begin
            rem_r  <= diff_s;
            qdig_r <= qdig_r + 4'd1;
          end else begin
            quo_r <= {quo_r[W-5:0], qdig_r};
            if (!last_s) begin
              cnt_r <= cnt_r - CW'(1'b1);
            end
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Output registers: status follows the next state, results load on DONE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient_r    <= {W{1'b0}};
      remainder_r   <= {W{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      div_by_zero_r <= 1'b0;
      bcd_err_r     <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_s == DONE);
      if (state_r == IDLE && start) begin
        if (!ops_ok_s) begin
          quotient_r    <= {W{1'b0}};
          remainder_r   <= {W{1'b0}};
          div_by_zero_r <= 1'b0;
          bcd_err_r     <= 1'b1;
        end else if (dvs_zero_s) begin
          quotient_r    <= {DIGITS{4'h9}};
          remainder_r   <= dividend;
          div_by_zero_r <= 1'b1;
          bcd_err_r     <= 1'b0;
        end
      end else if (state_r == SUB && !ge_s && last_s) begin
        quotient_r    <= {quo_r[W-5:0], qdig_r};
        remainder_r   <= rem_r[W-1:0];
        div_by_zero_r <= 1'b0;
        bcd_err_r     <= 1'b0;
      end
    end
  end

  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = div_by_zero_r;
  assign bcd_err     = bcd_err_r;

endmodule

// File: tb/tb_bcd_long_divider.sv
// -----------------------------------------------------------------------------
// tb_bcd_long_divider
// Self-checking bench: directed cases, start-ignore, mid-run reset, output hold
// and randomized operands checked against an integer-arithmetic reference.
// -----------------------------------------------------------------------------
module tb_bcd_long_divider;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int BUDGET = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic [W-1:0]  quotient, remainder;
  logic          busy, done, div_by_zero, bcd_err;

  int errors = 0;
  int checks = 0;

  bcd_long_divider #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (plain decimal arithmetic) ----------------
  function automatic int bcd2int(input logic [W-1:0] b);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] b = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  // Each quotient digit q_i costs q_i + 2 cycles.
  function automatic int model_latency(input int q);
    int t = q;
    int s = 0;
    for (int i = 0; i < DIGITS; i++) begin
      s += (t % 10) + 2;
      t = t / 10;
    end
    return s;
  endfunction

  // Drive one division; report latency (edges after the start edge), results,
  // whether busy stayed high, and whether done dropped with busy one cycle later.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dbz, output logic berr,
                         output logic bsy_all, output logic pulse_ok);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = W'($urandom);   // must not affect the running division
    divisor  = W'($urandom);
    lat = 0;
    bsy_all = (busy === 1'b1);
    while (done !== 1'b1 && lat < BUDGET) begin
      @(posedge clk); #1;
      lat++;
      if (busy !== 1'b1) bsy_all = 1'b0;
    end
    q = quotient; r = remainder; dbz = div_by_zero; berr = bcd_err;
    @(posedge clk); #1;
    pulse_ok = (done === 1'b0) && (busy === 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero, bcd_err} !== {(2*W+4){1'b0}}) begin
      errors++;
      $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b berr=%b, want all 0",
               quotient, remainder, busy, done, div_by_zero, bcd_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4]  = '{16'h1234, 16'h9999, 16'h0456, 16'h12A4};
    logic [W-1:0] tb [4]  = '{16'h0012, 16'h0001, 16'h0000, 16'h0003};
    logic [W-1:0] eq [4]  = '{16'h0102, 16'h9999, 16'h9999, 16'h0000};
    logic [W-1:0] er [4]  = '{16'h0010, 16'h0000, 16'h0456, 16'h0000};
    logic [1:0]   ef [4]  = '{2'b00, 2'b00, 2'b10, 2'b01};  // {dbz, berr}
    int           el [4]  = '{11, 44, 0, 0};
    int lat;
    logic [W-1:0] q, r;
    logic dbz, berr, bsy, pulse;
    for (int i = 0; i < 4; i++) begin
      run_div(ta[i], tb[i], lat, q, r, dbz, berr, bsy, pulse);
      checks++;
      if ({q, r, dbz, berr} !== {eq[i], er[i], ef[i]}) begin
        errors++;
        $display("FAIL directed_result %h/%h: got q=%h r=%h dbz=%b berr=%b, want q=%h r=%h flags=%b",
                 ta[i], tb[i], q, r, dbz, berr, eq[i], er[i], ef[i]);
      end
      checks++;
      if (lat !== el[i]) begin
        errors++;
        $display("FAIL directed_latency %h/%h: got %0d edges, want %0d", ta[i], tb[i], lat, el[i]);
      end
      checks++;
      if ({bsy, pulse} !== 2'b11) begin
        errors++;
        $display("FAIL directed_busy_done %h/%h: busy_held=%b single_pulse=%b, want 1 1",
                 ta[i], tb[i], bsy, pulse);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    dividend = 16'h0100; divisor = 16'h0007; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < BUDGET) begin
      @(negedge clk);
      start = (lat == 3);
      if (lat == 3) begin
        dividend = 16'h0999; divisor = 16'h0003;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    checks++;
    if ({quotient, remainder, lat} !== {16'h0014, 16'h0002, model_latency(14)}) begin
      errors++;
      $display("FAIL ignore_start: got q=%h r=%h lat=%0d, want q=0014 r=0002 lat=%0d",
               quotient, remainder, lat, model_latency(14));
    end
    // start raised while in DONE must not launch a new division
    @(negedge clk);
    dividend = 16'h0050; divisor = 16'h0007; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL start_in_done: got busy=%b done=%b, want 0 0", busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_done: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [W-1:0] q, r;
    logic dbz, berr, bsy, pulse, saw_done;
    @(negedge clk);
    dividend = 16'h9999; divisor = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero, bcd_err} !== {(2*W+4){1'b0}}) begin
      errors++;
      $display("FAIL reset_mid_outputs: got q=%h r=%h busy=%b done=%b, want all 0",
               quotient, remainder, busy, done);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_done: activity seen after abort=%b, want 0", saw_done);
    end
    run_div(16'h0050, 16'h0007, lat, q, r, dbz, berr, bsy, pulse);
    checks++;
    if ({q, r, dbz, berr, lat} !== {16'h0007, 16'h0001, 2'b00, model_latency(7)}) begin
      errors++;
      $display("FAIL reset_mid_restart: got q=%h r=%h flags=%b%b lat=%0d, want 0007 0001 00 %0d",
               q, r, dbz, berr, lat, model_latency(7));
    end
  endtask

  task automatic test_hold();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({quotient, remainder, done, busy} !== {16'h0007, 16'h0001, 2'b00}) begin
      errors++;
      $display("FAIL hold_result: got q=%h r=%h done=%b busy=%b, want 0007 0001 0 0",
               quotient, remainder, done, busy);
    end
  endtask

  task automatic test_random();
    int ai, bi, mag, kind, lat, elat;
    logic [W-1:0] a, b, q, r, eq, er;
    logic dbz, berr, bsy, pulse;
    logic [1:0] ef;
    for (int n = 0; n < 40; n++) begin
      ai   = int'($urandom_range(0, 9999));
      mag  = int'($urandom_range(1, 4));
      bi   = int'($urandom_range(1, (10 ** mag) - 1));
      kind = int'($urandom_range(0, 9));
      a = int2bcd(ai);
      b = (kind == 0) ? 16'h0000 : int2bcd(bi);
      if (kind == 1) a[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      if (kind == 2) b[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      if (kind == 1 || kind == 2) begin
        eq = '0; er = '0; ef = 2'b01; elat = 0;
      end else if (kind == 0) begin
        eq = 16'h9999; er = a; ef = 2'b10; elat = 0;
      end else begin
        eq = int2bcd(ai / bcd2int(b)); er = int2bcd(ai % bcd2int(b));
        ef = 2'b00; elat = model_latency(ai / bcd2int(b));
      end
      run_div(a, b, lat, q, r, dbz, berr, bsy, pulse);
      checks++;
      if ({q, r, dbz, berr, lat, bsy, pulse} !== {eq, er, ef, elat, 2'b11}) begin
        errors++;
        $display("FAIL random %h/%h: got q=%h r=%h flags=%b%b lat=%0d busy=%b pulse=%b, want q=%h r=%h flags=%b lat=%0d",
                 a, b, q, r, dbz, berr, lat, bsy, pulse, eq, er, ef, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
